// File: rtl/param_lifo_if.sv
// Handshake and status bundle for param_lifo.
// The master drives push/pop/data and the slave (the stack) returns data and status.
interface param_lifo_if #(
  parameter int unsigned Wl    = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic [Wl-1:0] din;
  logic          clr_err;
  logic [Wl-1:0] dout;
  logic          dout_valid;
  logic [Wl-1:0] top;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          error;

  modport master (
    output push, pop, din, clr_err,
    input  dout, dout_valid, top, count, full, empty, overflow, underflow, error
  );

  modport slave (
    input  push, pop, din, clr_err,
    output dout, dout_valid, top, count, full, empty, overflow, underflow, error
  );
endinterface

// File: rtl/param_lifo.sv
// Parameterised register-based LIFO stack with replace/bypass on simultaneous push+pop
// and sticky overflow/underflow flags.
module param_lifo #(
  parameter int unsigned Wl    = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic         clk,
  input logic         reset,
  param_lifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [Wl-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [Wl-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          full, empty;
  logic [CW-1:0] count_m1;
  logic [AW-1:0] top_idx, wr_idx, mem_idx;
  logic          mem_we;
  logic          of_set, uf_set;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - CW'(1);
  // Guard the empty case so the peek index never leaves the array.
  assign top_idx  = empty ? '0 : count_m1[AW-1:0];
  assign wr_idx   = full  ? '0 : count_q[AW-1:0];

  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = wr_idx;
    of_set       = 1'b0;
    uf_set       = 1'b0;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (full) begin
          of_set = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          uf_set = 1'b1;
        end else begin
          dout_d       = mem_q[top_idx];
          dout_valid_d = 1'b1;
          count_d      = count_m1;
        end
      end
      2'b11: begin
        dout_valid_d = 1'b1;
        if (empty) begin
          dout_d = bus.din;
        end else begin
          dout_d  = mem_q[top_idx];
          mem_we  = 1'b1;
          mem_idx = top_idx;
        end
      end
      default: ;
    endcase
    // A flag being set this cycle wins over a simultaneous clear.
    overflow_d  = of_set | (overflow_q  & ~bus.clr_err);
    underflow_d = uf_set | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; entries above count are never observed.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_idx] <= bus.din;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.top        = mem_q[top_idx];
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.error      = overflow_q | underflow_q;
endmodule

// File: tb/tb_param_lifo.sv
// Directed self-checking bench for param_lifo at three parameterisations.
module tb_param_lifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  param_lifo_if #(.Wl(8),  .DEPTH(5)) m_if ();
  param_lifo_if #(.Wl(1),  .DEPTH(2)) s_if ();
  param_lifo_if #(.Wl(16), .DEPTH(7)) w_if ();

  param_lifo #(.Wl(8),  .DEPTH(5)) u_main  (.clk(clk), .reset(reset), .bus(m_if));
  param_lifo #(.Wl(1),  .DEPTH(2)) u_small (.clk(clk), .reset(reset), .bus(s_if));
  param_lifo #(.Wl(16), .DEPTH(7)) u_wide  (.clk(clk), .reset(reset), .bus(w_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of main-instance stimulus, then inputs return to idle.
  task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic c);
    m_if.push    = p;
    m_if.pop     = q;
    m_if.din     = d;
    m_if.clr_err = c;
    step();
    m_if.push    = 1'b0;
    m_if.pop     = 1'b0;
    m_if.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [7:0]  vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [15:0] wv;

  initial begin
    m_if.push = 1'b0; m_if.pop = 1'b0; m_if.din = '0; m_if.clr_err = 1'b0;
    s_if.push = 1'b0; s_if.pop = 1'b0; s_if.din = '0; s_if.clr_err = 1'b0;
    w_if.push = 1'b0; w_if.pop = 1'b0; w_if.din = '0; w_if.clr_err = 1'b0;

    do_reset();
    check("rst_count", 32'(m_if.count), 32'd0);
    check("rst_empty", 32'(m_if.empty), 32'd1);
    check("rst_full",  32'(m_if.full),  32'd0);
    check("rst_error", 32'(m_if.error), 32'd0);
    check("rst_dout",  32'(m_if.dout),  32'd0);
    check("rst_dv",    32'(m_if.dout_valid), 32'd0);

    // Fill and drain in LIFO order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, vals[i], 1'b0);
      check("fill_count", 32'(m_if.count), 32'(i + 1));
      check("fill_top",   32'(m_if.top),   32'(vals[i]));
      check("fill_full",  32'(m_if.full),  (i == 4) ? 32'd1 : 32'd0);
      check("fill_dv",    32'(m_if.dout_valid), 32'd0);
    end
    for (int i = 4; i >= 0; i--) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      check("drain_dout",  32'(m_if.dout), 32'(vals[i]));
      check("drain_dv",    32'(m_if.dout_valid), 32'd1);
      check("drain_count", 32'(m_if.count), 32'(i));
    end
    check("drain_empty", 32'(m_if.empty), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_dv",   32'(m_if.dout_valid), 32'd0);
    check("idle_dout", 32'(m_if.dout), 32'h11);

    // Overflow while full, clear, and set-wins-over-clear.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, vals[i], 1'b0);
    drive(1'b1, 1'b0, 8'h66, 1'b0);
    check("ovf_count", 32'(m_if.count), 32'd5);
    check("ovf_flag",  32'(m_if.overflow), 32'd1);
    check("ovf_error", 32'(m_if.error), 32'd1);
    check("ovf_top",   32'(m_if.top), 32'h55);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_ovf",   32'(m_if.overflow), 32'd0);
    drive(1'b1, 1'b0, 8'h67, 1'b1);
    check("setwins_ovf", 32'(m_if.overflow), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr2_err",  32'(m_if.error), 32'd0);

    // Replace at full.
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    check("repfull_dout",  32'(m_if.dout), 32'h55);
    check("repfull_count", 32'(m_if.count), 32'd5);
    check("repfull_top",   32'(m_if.top), 32'h77);
    check("repfull_err",   32'(m_if.error), 32'd0);

    // Replace with two entries stored.
    do_reset();
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    drive(1'b1, 1'b0, 8'hA2, 1'b0);
    drive(1'b1, 1'b1, 8'hB0, 1'b0);
    check("rep_dout",  32'(m_if.dout), 32'hA2);
    check("rep_dv",    32'(m_if.dout_valid), 32'd1);
    check("rep_count", 32'(m_if.count), 32'd2);
    check("rep_top",   32'(m_if.top), 32'hB0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    check("rep_pop1", 32'(m_if.dout), 32'hB0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    check("rep_pop2", 32'(m_if.dout), 32'hA1);

    // Bypass when empty, then underflow.
    drive(1'b1, 1'b1, 8'h3C, 1'b0);
    check("byp_dout",  32'(m_if.dout), 32'h3C);
    check("byp_dv",    32'(m_if.dout_valid), 32'd1);
    check("byp_count", 32'(m_if.count), 32'd0);
    check("byp_err",   32'(m_if.error), 32'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    check("udf_flag", 32'(m_if.underflow), 32'd1);
    check("udf_dout", 32'(m_if.dout), 32'h3C);
    check("udf_dv",   32'(m_if.dout_valid), 32'd0);
    check("udf_cnt",  32'(m_if.count), 32'd0);

    // Reset beats a simultaneous push mid-sequence.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, vals[i], 1'b0);
    check("pre_rst_count", 32'(m_if.count), 32'd3);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h99, 1'b0);
    reset = 1'b0;
    check("rstpush_count", 32'(m_if.count), 32'd0);
    check("rstpush_empty", 32'(m_if.empty), 32'd1);
    check("rstpush_dv",    32'(m_if.dout_valid), 32'd0);
    check("rstpush_err",   32'(m_if.error), 32'd0);

    // Wl=1, DEPTH=2: push 1 then 0, pop 0 then 1.
    s_if.push = 1'b1; s_if.din = 1'b1; step();
    check("s_full1", 32'(s_if.full), 32'd0);
    s_if.din = 1'b0; step();
    s_if.push = 1'b0;
    check("s_full2", 32'(s_if.full), 32'd1);
    check("s_count", 32'(s_if.count), 32'd2);
    check("s_top",   32'(s_if.top), 32'd0);
    s_if.pop = 1'b1; step();
    check("s_pop1",  32'(s_if.dout), 32'd0);
    check("s_empty1", 32'(s_if.empty), 32'd0);
    step();
    s_if.pop = 1'b0;
    check("s_pop2",  32'(s_if.dout), 32'd1);
    check("s_dv2",   32'(s_if.dout_valid), 32'd1);
    check("s_empty2", 32'(s_if.empty), 32'd1);

    // Wl=16, DEPTH=7: push 0x1111..0x7777, pop in reverse.
    for (int i = 0; i < 7; i++) begin
      wv = 16'(16'h1111 * (i + 1));
      w_if.push = 1'b1; w_if.din = wv; step();
      check("w_full", 32'(w_if.full), (i == 6) ? 32'd1 : 32'd0);
    end
    w_if.push = 1'b0;
    check("w_top", 32'(w_if.top), 32'h7777);
    for (int i = 6; i >= 0; i--) begin
      wv = 16'(16'h1111 * (i + 1));
      w_if.pop = 1'b1; step();
      check("w_dout",  32'(w_if.dout), 32'(wv));
      check("w_empty", 32'(w_if.empty), (i == 0) ? 32'd1 : 32'd0);
    end
    w_if.pop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/param_lifo.md
PARAM_LIFO -- requirements
Module: param_lifo

Interface
REQ-001 Parameter Wl, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8, number of stack entries; SHALL be >= 2, any integer (not restricted to a power of two).
REQ-003 Localparam CW = $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push  input  1  write din onto the stack this cycle.
REQ-007 pop  input  1  remove top entry and return it on dout.
REQ-008 din  input  Wl  push data.
REQ-009 clr_err  input  1  clears sticky overflow/underflow flags.
REQ-010 dout  output  Wl  registered pop data.
REQ-011 dout_valid  output  1  one-cycle pulse, dout carries a popped/bypassed word.
REQ-012 top  output  Wl  combinational peek of mem[count-1]; value is don't-care when empty=1.
REQ-013 count  output  CW  current occupancy, 0..DEPTH.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow  output  1  sticky: push rejected while full.
REQ-017 underflow  output  1  sticky: pop rejected while empty.
REQ-018 error  output  1  overflow | underflow.

Function
REQ-019 Storage SHALL be DEPTH x Wl registers; entry i is valid iff i < count; count is the only pointer.
REQ-020 full and empty SHALL be decoded from the count register; they never glitch mid-cycle.
REQ-021 push=1, pop=0, full=0: mem[count] <= din; count <= count+1; dout_valid <= 0.
REQ-022 push=0, pop=1, empty=0: dout <= mem[count-1]; dout_valid <= 1; count <= count-1; pop-to-data latency is one clock.
REQ-023 push=1, pop=1, empty=0 (including full=1): replace top; dout <= mem[count-1]; mem[count-1] <= din; dout_valid <= 1; count unchanged; no flag set.
REQ-024 push=1, pop=1, empty=1: bypass; dout <= din; dout_valid <= 1; count stays 0; no flag set.
REQ-025 push=1, pop=0, full=1: write ignored; count, mem unchanged; overflow <= 1.
REQ-026 push=0, pop=1, empty=1: no state change; dout holds; dout_valid <= 0; underflow <= 1.
REQ-027 push=0, pop=0: count and mem hold; dout holds; dout_valid <= 0.
REQ-028 dout SHALL hold its last value whenever dout_valid is 0.
REQ-029 clr_err=1 SHALL clear overflow and underflow next edge, except a flag whose set condition occurs in the same cycle SHALL be 1 (set wins).
REQ-030 count arithmetic SHALL never wrap; it saturates by rejection at 0 and DEPTH.
REQ-031 top SHALL reflect the new top in the cycle after any push, pop or replace.

Reset
REQ-032 reset=1 at a rising edge SHALL force count=0, dout=0, dout_valid=0, overflow=0, underflow=0; hence empty=1, full=0, error=0.
REQ-033 reset SHALL take priority over push, pop and clr_err in the same cycle, including mid-sequence with count>0.
REQ-034 Memory contents SHALL NOT be cleared by reset; they are unobservable until rewritten.

Verification (Wl=8, DEPTH=5 unless stated)
REQ-035 Push 0x11,0x22,0x33,0x44,0x55 -> full=1, count=5, top=0x55; then 5 pops -> dout 0x55,0x44,0x33,0x22,0x11 each one cycle after its pop with dout_valid pulsed, empty=1 at end.
REQ-036 At full, push 0x66 -> count stays 5, overflow=1, error=1, top=0x55; clr_err=1 -> overflow=0 next cycle.
REQ-037 With 0xA1,0xA2 stored, push=1 pop=1 din=0xB0 -> dout=0xA2, dout_valid=1, count=2, top=0xB0.
REQ-038 Empty, push=1 pop=1 din=0x3C -> dout=0x3C, dout_valid=1, count=0, no flags; then pop alone -> underflow=1, dout stays 0x3C, dout_valid=0.
REQ-039 Count=3, reset=1 together with push=1 -> count=0, empty=1, dout_valid=0, flags 0.
REQ-040 Repeat REQ-035 with Wl=1, DEPTH=2 and with Wl=16, DEPTH=7 -> identical LIFO ordering and full/empty timing.
